// File: rtl/cube_pkg.sv
// Shared colour codes, FSM states and centre table for the cube entry sequencer.
// The centre table is only consumed when CENTRE_AUTOFILL_EN is defined.
package cube_pkg;

    localparam logic [2:0] COL_NONE   = 3'b000;
    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_ORANGE = 3'b101;
    localparam logic [2:0] COL_GREEN  = 3'b010;
    localparam logic [2:0] COL_BLUE   = 3'b011;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_YELLOW = 3'b110;

    localparam int NUM_STICKERS = 54;
    localparam int NUM_COLOURS  = 6;
    localparam int ADDR_W       = $clog2(NUM_STICKERS);

    localparam logic [3:0] CENTRE_STICKER = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATE,
        S_WAIT_COLOUR,
        S_WRITE,
        S_RELEASE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    // 3'b001 is a reserved "none", so any code with bit 2 or bit 1 set is a colour
    function automatic logic is_colour(input logic [2:0] code);
        return code[2] | code[1];
    endfunction

    function automatic logic [2:0] centre_colour(input logic [2:0] face);
        logic [2:0] col;
        case (face)
            3'd0:    col = COL_WHITE;
            3'd1:    col = COL_YELLOW;
            3'd2:    col = COL_RED;
            3'd3:    col = COL_ORANGE;
            3'd4:    col = COL_GREEN;
            default: col = COL_BLUE;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/cube_entry_sequencer_if.sv
// Control, chooser and cube-store signals of the entry sequencer.
// slave is the sequencer side, master is the UI / chooser / store side.
interface cube_entry_sequencer_if;
    import cube_pkg::*;

    logic              start;
    logic              abort;
    logic [2:0]        colour_in;
    logic              touch_input;
    logic              chooser_active;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_data;
    logic [2:0]        face_idx;
    logic [3:0]        sticker_idx;
    logic              busy;
    logic              done;
    logic              valid_cube;

    modport slave (
        input  start,
        input  abort,
        input  colour_in,
        input  touch_input,
        output chooser_active,
        output wr_en,
        output wr_addr,
        output wr_data,
        output face_idx,
        output sticker_idx,
        output busy,
        output done,
        output valid_cube
    );

    modport master (
        output start,
        output abort,
        output colour_in,
        output touch_input,
        input  chooser_active,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  face_idx,
        input  sticker_idx,
        input  busy,
        input  done,
        input  valid_cube
    );

endinterface

// File: rtl/cube_entry_sequencer_colour_tally.sv
// Six saturating 4-bit per-colour counters; all_nine flags a balanced cube.
module colour_tally
    import cube_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_clr,
    input  logic       i_inc,
    input  logic [2:0] i_code,
    output logic       o_all_nine
);

    logic [3:0]             r_cnt [NUM_COLOURS];
    logic [NUM_COLOURS-1:0] w_hit;

    always_comb begin
        w_hit = '0;
        case (i_code)
            COL_RED:    w_hit[0] = 1'b1;
            COL_ORANGE: w_hit[1] = 1'b1;
            COL_GREEN:  w_hit[2] = 1'b1;
            COL_BLUE:   w_hit[3] = 1'b1;
            COL_WHITE:  w_hit[4] = 1'b1;
            COL_YELLOW: w_hit[5] = 1'b1;
            default:    w_hit    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            for (int i = 0; i < NUM_COLOURS; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (i_inc) begin
            for (int i = 0; i < NUM_COLOURS; i++) begin
                if (w_hit[i] && (r_cnt[i] != 4'hF)) begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        o_all_nine = 1'b1;
        for (int i = 0; i < NUM_COLOURS; i++) begin
            if (r_cnt[i] != 4'd9) begin
                o_all_nine = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cube_entry_sequencer.sv
// Walks all stickers through the colour chooser and writes them to the cube store.
// Define CENTRE_AUTOFILL_EN to write each face centre from a fixed table instead.
module cube_entry_sequencer
    import cube_pkg::*;
#(
    parameter logic [15:0] SETTLE_CYCLES     = 16'd1000,
    parameter int          NUM_FACES         = 6,
    parameter int          STICKERS_PER_FACE = 9
) (
    input logic                   clk,
    input logic                   reset,
    cube_entry_sequencer_if.slave bus
);

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_face;
    logic [2:0]  w_face;
    logic [3:0]  r_sticker;
    logic [3:0]  w_sticker;
    logic [2:0]  r_data;
    logic [2:0]  w_data;
    logic [15:0] r_settle;
    logic [15:0] w_settle;
    logic        r_valid;
    logic        w_valid;

    logic        w_clr;
    logic        w_inc;
    logic        w_all_nine;
    logic        w_wrap;
    logic        w_last;
    logic [2:0]  w_adv_face;
    logic [3:0]  w_adv_sticker;

    assign w_wrap = (r_sticker == 4'(STICKERS_PER_FACE - 1));
    assign w_last = w_wrap && (r_face == 3'(NUM_FACES - 1));

    assign w_adv_sticker = w_wrap ? 4'd0 : r_sticker + 4'd1;
    assign w_adv_face    = w_wrap ? r_face + 3'd1 : r_face;

    assign w_inc = (r_state == S_WRITE);

    colour_tally u_tally (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_clr),
        .i_inc      (w_inc),
        .i_code     (r_data),
        .o_all_nine (w_all_nine)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_face    <= '0;
            r_sticker <= '0;
            r_data    <= COL_NONE;
            r_settle  <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_face    <= w_face;
            r_sticker <= w_sticker;
            r_data    <= w_data;
            r_settle  <= w_settle;
            r_valid   <= w_valid;
        end
    end

    // abort overrides every state transition, including a colour arriving
    always_comb begin
        w_next    = r_state;
        w_face    = r_face;
        w_sticker = r_sticker;
        w_data    = r_data;
        w_settle  = r_settle;
        w_valid   = r_valid;
        w_clr     = 1'b0;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_clr     = 1'b1;
                        w_face    = '0;
                        w_sticker = '0;
                        w_valid   = 1'b0;
                        w_next    = S_ACTIVATE;
                    end
                end
                S_ACTIVATE: begin
                    w_next = S_WAIT_COLOUR;
                end
                S_WAIT_COLOUR: begin
                    if (is_colour(bus.colour_in)) begin
                        w_data = bus.colour_in;
                        w_next = S_WRITE;
                    end
                end
                S_WRITE: begin
`ifdef CENTRE_AUTOFILL_EN
                    if (r_sticker == CENTRE_STICKER) begin
                        w_sticker = w_adv_sticker;
                        w_next    = S_ACTIVATE;
                    end else begin
                        w_next = S_RELEASE;
                    end
`else
                    w_next = S_RELEASE;
`endif
                end
                S_RELEASE: begin
                    if ((bus.colour_in == COL_NONE) && !bus.touch_input) begin
                        w_settle = SETTLE_CYCLES;
                        w_next   = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle != 16'd0) begin
                        w_settle = r_settle - 16'd1;
                    end else if (w_last) begin
                        w_face    = '0;
                        w_sticker = '0;
                        w_next    = S_CHECK;
                    end else begin
                        w_face    = w_adv_face;
                        w_sticker = w_adv_sticker;
`ifdef CENTRE_AUTOFILL_EN
                        if (w_adv_sticker == CENTRE_STICKER) begin
                            w_data = centre_colour(w_adv_face);
                            w_next = S_WRITE;
                        end else begin
                            w_next = S_ACTIVATE;
                        end
`else
                        w_next = S_ACTIVATE;
`endif
                    end
                end
                S_CHECK: begin
                    w_valid = w_all_nine;
                    w_next  = S_DONE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    assign bus.chooser_active = (r_state == S_ACTIVATE) || (r_state == S_WAIT_COLOUR);
    assign bus.wr_en          = (r_state == S_WRITE);
    assign bus.wr_addr        = {r_face, 3'b000} + {3'b000, r_face} + {2'b00, r_sticker};
    assign bus.wr_data        = r_data;
    assign bus.face_idx       = r_face;
    assign bus.sticker_idx    = r_sticker;
    assign bus.busy           = (r_state != S_IDLE) && (r_state != S_DONE);
    assign bus.done           = (r_state == S_DONE);
    assign bus.valid_cube     = r_valid && (r_state == S_DONE);

endmodule

// File: doc/cube_entry_sequencer.md
Name: cube_entry_sequencer

Overview:
- Sequences the colour-choice touch screen through all 54 stickers of the cube: faces 0..5, stickers 0..8 in row-major order.
- For each sticker: raises the chooser's active input, waits for a non-zero colour code, writes it to the cube-state store, then releases the chooser and waits for it to return to idle.
- Keeps per-colour tallies and reports at the end whether the entered cube has exactly 9 stickers of each colour.
- Sits between the top-level UI/mode logic, the colour-choice screen and the cube-state RAM.

Parameters:
- SETTLE_CYCLES, 16'd1000, idle gap in clk cycles after each sticker release before the next activation.
- NUM_FACES, 6, faces to enter.
- STICKERS_PER_FACE, 9, stickers per face.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a full entry pass when idle
- abort  in  1  returns the block to IDLE from any state
- colour_in  in  3  colour code from the chooser; 0 = none
- touch_input  in  1  raw touch-present flag
- chooser_active  out  1  enable to the colour-choice screen
- wr_en  out  1  single-cycle write strobe to the cube-state store
- wr_addr  out  6  face*9 + sticker, range 0..53
- wr_data  out  3  colour code written
- face_idx  out  3  current face, 0..5
- sticker_idx  out  4  current sticker, 0..8
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- valid_cube  out  1  in DONE, high iff all six colour tallies equal 9

Behaviour:
- Reset: state IDLE. All outputs 0. face_idx = 0, sticker_idx = 0, tallies = 0.
- Colour codes:
  - 3'b100 red, 3'b101 orange, 3'b010 green, 3'b011 blue, 3'b111 white, 3'b110 yellow.
  - 3'b000 and 3'b001 are not colours; 3'b001 is treated as none.
- IDLE: start=1 → clear tallies, face_idx = 0, sticker_idx = 0, go to ACTIVATE. start is ignored in every other state except DONE.
- ACTIVATE: chooser_active = 1; go to WAIT_COLOUR on the next cycle.
- WAIT_COLOUR:
  - Hold chooser_active = 1.
  - On the first cycle colour_in is a valid code: latch it into wr_data and go to WRITE.
  - No timeout.
- WRITE:
  - wr_en = 1 for exactly one cycle, with wr_addr = face_idx*9 + sticker_idx and wr_data = the latched code.
  - Increment the matching tally (4-bit, saturating at 15).
  - Go to RELEASE.
- RELEASE:
  - chooser_active = 0.
  - Stay until colour_in == 0 AND touch_input == 0 in the same cycle. This guarantees one touch cannot select two stickers.
  - Then load the settle counter with SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - Count down to 0.
  - At 0, advance the index: sticker_idx == 8 wraps to 0 and face_idx increments. The next state is CHECK when face_idx was 5 and sticker_idx was 8, otherwise ACTIVATE.
  - SETTLE_CYCLES = 0 gives a one-cycle SETTLE.
- CHECK: compute valid_cube from the tallies; go to DONE next cycle.
- DONE:
  - done = 1; valid_cube is held.
  - start=1 → behaves as the IDLE start (restarts the pass; done and valid_cube clear the same cycle).
- abort, from any state: next cycle IDLE, chooser_active = 0, wr_en = 0. Tallies are kept until the next start.
- reset mid-pass: identical to the reset values; no write is issued in the reset cycle.
- Simultaneous events:
  - abort has priority over start and over a colour arriving.
  - reset has priority over everything.
- wr_addr arithmetic is 6-bit: face_idx*8 + face_idx + sticker_idx. It never exceeds 53.
- Latency:
  - Valid colour_in in WAIT_COLOUR → wr_en exactly 1 cycle later.
  - Release condition met → next chooser_active rise after SETTLE_CYCLES + 2 cycles.

Optional Feature:
- Macro: CENTRE_AUTOFILL_EN.
- Defined:
  - Sticker 4 of each face is never offered to the chooser.
  - From SETTLE, the index advances straight to a WRITE of sticker 4 with the fixed centre colour for that face: face 0..5 → white, yellow, red, orange, green, blue. That write goes through the same tally path.
  - The block then advances to sticker 5 and continues as normal, skipping RELEASE and SETTLE for the centre.
- Undefined: all 9 stickers are entered by touch.

Decomposition:
- Package cube_pkg holds:
  - the colour code localparams (COL_NONE, COL_RED, COL_ORANGE, COL_GREEN, COL_BLUE, COL_WHITE, COL_YELLOW);
  - the state enum;
  - the NUM_STICKERS = 54 constant;
  - the centre colour table.
- Sub-module colour_tally: six saturating counters with a clear input, an increment input plus a 3-bit code input, and an all_nine output.

Test Plan:
- reset, then start; chooser model returns 3'b100 after 5 cycles for every sticker → 54 wr_en pulses with addresses 0..53 in order and wr_data 3'b100; DONE with valid_cube = 0.
- Model supplies 9 of each colour, SETTLE_CYCLES = 3 → done = 1, valid_cube = 1; the gap from release to the next chooser_active rise is 5 cycles.
- Hold touch_input = 1 for 20 cycles after the write of sticker 0 → block stays in RELEASE with chooser_active = 0; no second write until touch_input falls.
- abort asserted in WAIT_COLOUR at face 2, sticker 3 → next cycle IDLE, busy = 0, chooser_active = 0, no wr_en; a later start writes address 0 first.
- reset asserted the same cycle a valid colour_in appears → no wr_en; all outputs 0 on the next cycle.
- With CENTRE_AUTOFILL_EN defined → 48 chooser activations; addresses 4, 13, …, 49 are written with codes 111, 110, 100, 101, 010, 011 without chooser_active rising.
